// File: rtl/gate_truth_checker.sv
// Self-test engine for the two-input gate block: sweeps {a,b} through 00..11,
// samples the six gate outputs after SETTLE_CYCLES extra cycles, and reports pass/fail.
module gate_truth_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       andc,
   input  logic       orc,
   input  logic       nandc,
   input  logic       norc,
   input  logic       xorc,
   input  logic       xnorc,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] fail_count,
   output logic [1:0] err_vec,
   output logic [5:0] err_mask
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

   state_t     state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic       a_q, a_d, b_q, b_d;
   logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [2:0] fail_q, fail_d;
   logic [1:0] err_vec_q, err_vec_d;
   logic [5:0] err_mask_q, err_mask_d;
   logic [5:0] exp_v, mask;

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      err_vec_d  = err_vec_q;
      err_mask_d = err_mask_q;

      // Bit order matches err_mask: {xnor,xor,nor,nand,or,and}.
      exp_v = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), a_q | b_q, a_q & b_q};
      mask  = exp_v ^ {xnorc, xorc, norc, nandc, orc, andc};

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               vec_d      = 2'd0;
               a_d        = 1'b0;
               b_d        = 1'b0;
               cnt_d      = SETTLE;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               fail_d     = 3'd0;
               err_vec_d  = 2'd0;
               err_mask_d = 6'd0;
            end
         end
         RUN: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (mask != 6'd0) begin
                  fail_d = fail_q + 3'd1;
                  if (fail_q == 3'd0) begin
                     err_vec_d  = {a_q, b_q};
                     err_mask_d = mask;
                  end
               end
               if (vec_q != 2'd3) begin
                  vec_d      = vec_q + 2'd1;
                  {a_d, b_d} = vec_q + 2'd1;
                  cnt_d      = SETTLE;
               end else begin
                  // pass must include the verdict of the vector compared on this edge.
                  state_d = DONE;
                  vec_d   = 2'd0;
                  a_d     = 1'b0;
                  b_d     = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (fail_d == 3'd0);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         vec_q      <= 2'd0;
         cnt_q      <= 4'd0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 3'd0;
         err_vec_q  <= 2'd0;
         err_mask_q <= 6'd0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         err_vec_q  <= err_vec_d;
         err_mask_q <= err_mask_d;
      end
   end

   assign a          = a_q;
   assign b          = b_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_count = fail_q;
   assign err_vec    = err_vec_q;
   assign err_mask   = err_mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a modelled gate block with injectable per-vector faults,
// one DUT at SETTLE_CYCLES=2 and one at SETTLE_CYCLES=0.
module tb_gate_truth_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start1 = 1'b0;
   always #5 clk = ~clk;

   logic       a, b, busy, done, pass;
   logic [2:0] fail_count;
   logic [1:0] err_vec;
   logic [5:0] err_mask;
   logic       andc, orc, nandc, norc, xorc, xnorc;

   logic       a1, b1, busy1, done1, pass1;
   logic [2:0] fail_count1;
   logic [1:0] err_vec1;
   logic [5:0] err_mask1;

   // Per-vector corruption of the gate outputs, bits {xnor,xor,nor,nand,or,and}.
   logic [5:0] fault [4];
   logic [5:0] truth, gout;

   int passed = 0;
   int total  = 0;

   always_comb begin
      truth = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
      gout  = truth ^ fault[{a, b}];
   end
   assign {xnorc, xorc, norc, nandc, orc, andc} = gout;

   gate_truth_checker #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .andc(andc), .orc(orc), .nandc(nandc), .norc(norc), .xorc(xorc), .xnorc(xnorc),
      .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
      .err_vec(err_vec), .err_mask(err_mask)
   );

   gate_truth_checker #(.SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .andc(a1 & b1), .orc(a1 | b1), .nandc(~(a1 & b1)), .norc(~(a1 | b1)),
      .xorc(a1 ^ b1), .xnorc(~(a1 ^ b1)),
      .busy(busy1), .done(done1), .pass(pass1), .fail_count(fail_count1),
      .err_vec(err_vec1), .err_mask(err_mask1)
   );

   task automatic set_faults(input logic [5:0] f0, input logic [5:0] f1,
                             input logic [5:0] f2, input logic [5:0] f3);
      fault[0] = f0; fault[1] = f1; fault[2] = f2; fault[3] = f3;
   endtask

   // One run with SETTLE=2; start re-pulsed at cycle repulse_k (negative = never).
   task automatic run_vectors(input string name, input int repulse_k);
      int         exp_fc;
      logic [1:0] exp_ev;
      logic [5:0] exp_em;
      logic [3:0] exp_seq;
      exp_fc = 0; exp_ev = 2'd0; exp_em = 6'd0;
      for (int v = 0; v < 4; v++) begin
         if (fault[v] != 6'd0) begin
            if (exp_fc == 0) begin
               exp_ev = 2'(v);
               exp_em = fault[v];
            end
            exp_fc++;
         end
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         // {busy,done,a,b}: vector index advances every 3 cycles, done on the 12th.
         if (k < 12) exp_seq = {2'b10, 2'(k / 3)};
         else        exp_seq = 4'b0100;
         total++;
         if ({busy, done, a, b} !== exp_seq)
            $display("FAIL %s seq k=%0d: got %b exp %b", name, k, {busy, done, a, b}, exp_seq);
         else passed++;
         start = (k == repulse_k);
      end
      start = 1'b0;
      total++;
      if ({pass, fail_count, err_vec, err_mask} !== {(exp_fc == 0), 3'(exp_fc), exp_ev, exp_em})
         $display("FAIL %s result: got pass=%b fc=%0d ev=%b em=%b exp pass=%b fc=%0d ev=%b em=%b",
                  name, pass, fail_count, err_vec, err_mask, (exp_fc == 0), exp_fc, exp_ev, exp_em);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({done, busy, fail_count} !== {2'b10, 3'(exp_fc)})
         $display("FAIL %s hold: got done=%b busy=%b fc=%0d", name, done, busy, fail_count);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if ({a, b, busy, done, pass, fail_count, err_vec, err_mask} !== 15'd0)
         $display("FAIL reset_outputs: got %b exp 0", {a, b, busy, done, pass, fail_count, err_vec, err_mask});
      else passed++;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, busy1, done1} !== 4'd0)
         $display("FAIL reset_idle: got %b exp 0000", {busy, done, busy1, done1});
      else passed++;
   endtask

   task automatic test_golden();
      set_faults(6'd0, 6'd0, 6'd0, 6'd0);
      run_vectors("golden", -1);
   endtask

   task automatic test_and_stuck0();
      set_faults(6'd0, 6'd0, 6'd0, 6'b000001);
      run_vectors("and_stuck0", -1);
   endtask

   task automatic test_xor_swap();
      set_faults(6'b110000, 6'b110000, 6'b110000, 6'b110000);
      run_vectors("xor_swap", -1);
   endtask

   task automatic test_start_ignored();
      set_faults(6'd0, 6'd0, 6'd0, 6'd0);
      run_vectors("restart_ignored", 4);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         for (int v = 0; v < 4; v++)
            fault[v] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_vectors("random", -1);
      end
   endtask

   task automatic test_back_to_back();
      set_faults(6'b110000, 6'b110000, 6'b110000, 6'b110000);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 26; k++) begin
         @(posedge clk); #1;
         total++;
         if ({done, busy} !== ((k % 13 == 12) ? 2'b10 : 2'b01))
            $display("FAIL b2b k=%0d: got done=%b busy=%b", k, done, busy);
         else passed++;
         if (k == 12 || k == 13) begin
            total++;
            if (fail_count !== ((k == 12) ? 3'd4 : 3'd0) || err_mask !== ((k == 12) ? 6'b110000 : 6'd0))
               $display("FAIL b2b_results k=%0d: got fc=%0d em=%b", k, fail_count, err_mask);
            else passed++;
         end
      end
      start = 1'b0;
      repeat (14) @(posedge clk);
   endtask

   task automatic test_reset_midrun();
      set_faults(6'd0, 6'd0, 6'd0, 6'b000001);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      total++;
      if ({busy, a, b} !== 3'b110)
         $display("FAIL rst_mid_pre: got %b exp 110", {busy, a, b});
      else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if ({a, b, busy, done, pass, fail_count, err_vec, err_mask} !== 15'd0)
         $display("FAIL rst_mid_async: got %b exp 0", {a, b, busy, done, pass, fail_count, err_vec, err_mask});
      else passed++;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      total++;
      if ({a, b, busy, done, fail_count} !== 7'd0)
         $display("FAIL rst_mid_idle: got %b exp 0", {a, b, busy, done, fail_count});
      else passed++;
   endtask

   task automatic test_settle0();
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         total++;
         if ({busy1, done1, a1, b1} !== ((k < 4) ? {2'b10, 2'(k)} : 4'b0100))
            $display("FAIL settle0 k=%0d: got %b", k, {busy1, done1, a1, b1});
         else passed++;
      end
      total++;
      if ({pass1, fail_count1, err_mask1} !== {1'b1, 3'd0, 6'd0})
         $display("FAIL settle0_result: got pass=%b fc=%0d em=%b", pass1, fail_count1, err_mask1);
      else passed++;
   endtask

   initial begin
      set_faults(6'd0, 6'd0, 6'd0, 6'd0);
      test_reset();
      test_golden();
      test_and_stuck0();
      test_xor_swap();
      test_start_ignored();
      test_random();
      test_back_to_back();
      test_reset_midrun();
      test_settle0();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
